// File: rtl/ioctl_pkg.sv
// Shared types and widths for the data_io upload/download SDRAM path.
package ioctl_pkg;

    localparam int IOCTL_AW = 25;
    localparam int WORD_AW  = 23;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PFETCH,
        PF_THEN_FETCH
    } rd_state_e;

    function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/ioctl_upload_reader_toggle_req_port.sv
// Toggle-style request port: owns the req toggle and word address, detects completion
// when ack catches up with req, and re-aligns req to ack on the first cycle out of reset.
module toggle_req_port
    import ioctl_pkg::*;
#(
    parameter int AW = WORD_AW
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          issue_i,
    input  logic [AW-1:0] addr_i,
    input  logic          ack_i,
    output logic          req_o,
    output logic [AW-1:0] addr_o,
    output logic          ready_o,
    output logic          pending_o,
    output logic          done_o
);

    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          pending_q, pending_d;
    logic          init_q, init_d;

    assign done_o    = pending_q & (ack_i == req_q);
    assign req_o     = req_q;
    assign addr_o    = addr_q;
    assign ready_o   = ~init_q;
    assign pending_o = pending_q;

    // An issue in the completion cycle keeps the port busy with the new request.
    always_comb begin
        req_d     = req_q;
        addr_d    = addr_q;
        pending_d = pending_q;
        init_d    = 1'b0;
        if (init_q) begin
            req_d = ack_i;
        end else if (issue_i) begin
            req_d     = ~req_q;
            addr_d    = addr_i;
            pending_d = 1'b1;
        end else if (done_o) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req_q     <= 1'b0;
            addr_q    <= '0;
            pending_q <= 1'b0;
            init_q    <= 1'b1;
        end else begin
            req_q     <= req_d;
            addr_q    <= addr_d;
            pending_q <= pending_d;
            init_q    <= init_d;
        end
    end

endmodule

// File: rtl/ioctl_upload_reader.sv
// Serves data_io upload byte reads from SDRAM through a toggle word port, keeping the
// current word plus one prefetched word so sequential uploads only stall on misses.
module ioctl_upload_reader
    import ioctl_pkg::*;
#(
    parameter logic [IOCTL_AW-1:0] BASE_ADDR = '0,
    parameter bit                  PREFETCH  = 1'b1
) (
    input  logic                clk_sys_i,
    input  logic                reset_n_i,
    input  logic                ioctl_upload_i,
    input  logic                ioctl_rd_i,
    input  logic [IOCTL_AW-1:0] ioctl_addr_i,
    output logic [7:0]          ioctl_din_o,
    output logic                ioctl_busy_o,
    output logic                port_req_o,
    input  logic                port_ack_i,
    output logic [WORD_AW-1:0]  port_a_o,
    output logic [1:0]          port_ds_o,
    output logic                port_we_o,
    output logic [15:0]         port_d_o,
    input  logic [15:0]         port_q_i
);

    rd_state_e          state_q, state_d;
    logic [WORD_AW-1:0] cur_tag_q, cur_tag_d, nxt_tag_q, nxt_tag_d;
    logic [15:0]        cur_data_q, cur_data_d, nxt_data_q, nxt_data_d;
    logic               cur_v_q, cur_v_d, nxt_v_q, nxt_v_d;
    logic [7:0]         din_q, din_d;
    logic               busy_q, busy_d;
    logic [WORD_AW-1:0] pend_word_q, pend_word_d;
    logic               pend_hi_q, pend_hi_d;
    logic               pf_demand_q, pf_demand_d;
    logic               stale_q, stale_d;
    logic               upload_q;

    logic [IOCTL_AW-1:0] off;
    logic [WORD_AW-1:0]  rd_word;
    logic                rd_hi;
    logic                unused_off_msb;
    logic                upl_edge, rd_ok, discard;
    logic                issue;
    logic [WORD_AW-1:0]  issue_addr;
    logic                port_ready, port_pending, port_done;
    logic [WORD_AW-1:0]  port_addr;

    assign off            = ioctl_addr_i - BASE_ADDR;
    assign rd_word        = off[IOCTL_AW-2:1];
    assign rd_hi          = off[0];
    assign unused_off_msb = off[IOCTL_AW-1];
    assign upl_edge       = ioctl_upload_i ^ upload_q;
    assign rd_ok          = ioctl_rd_i & port_ready & ~busy_q;

    toggle_req_port #(.AW(WORD_AW)) u_port (
        .clk_i     (clk_sys_i),
        .rst_n_i   (reset_n_i),
        .issue_i   (issue),
        .addr_i    (issue_addr),
        .ack_i     (port_ack_i),
        .req_o     (port_req_o),
        .addr_o    (port_addr),
        .ready_o   (port_ready),
        .pending_o (port_pending),
        .done_o    (port_done)
    );

    // Completion is resolved first, then a read is looked up against the updated buffers.
    // Data of a request that straddled an upload edge is dropped; a waiting read refetches.
    always_comb begin
        state_d     = state_q;
        cur_tag_d   = cur_tag_q;
        cur_data_d  = cur_data_q;
        cur_v_d     = cur_v_q;
        nxt_tag_d   = nxt_tag_q;
        nxt_data_d  = nxt_data_q;
        nxt_v_d     = nxt_v_q;
        din_d       = din_q;
        busy_d      = busy_q;
        pend_word_d = pend_word_q;
        pend_hi_d   = pend_hi_q;
        pf_demand_d = pf_demand_q;
        stale_d     = stale_q;
        discard     = stale_q | upl_edge;
        issue       = 1'b0;
        issue_addr  = pend_word_q;

        if (upl_edge) begin
            cur_v_d = 1'b0;
            nxt_v_d = 1'b0;
            if (port_pending && !port_done) stale_d = 1'b1;
        end

        if (port_done) begin
            stale_d     = 1'b0;
            pf_demand_d = 1'b0;
            unique case (state_q)
                FETCH, PFETCH: begin
                    if (state_q == PFETCH && !pf_demand_q) begin
                        if (!discard) begin
                            nxt_tag_d  = port_addr;
                            nxt_data_d = port_q_i;
                            nxt_v_d    = 1'b1;
                        end
                        state_d = IDLE;
                    end else if (discard) begin
                        issue      = 1'b1;
                        issue_addr = pend_word_q;
                        state_d    = FETCH;
                    end else begin
                        cur_tag_d  = port_addr;
                        cur_data_d = port_q_i;
                        cur_v_d    = 1'b1;
                        din_d      = byte_sel(port_q_i, pend_hi_q);
                        busy_d     = 1'b0;
                        state_d    = IDLE;
                        if (PREFETCH && state_q == FETCH) begin
                            issue      = 1'b1;
                            issue_addr = port_addr + 1'b1;
                            nxt_v_d    = 1'b0;
                            state_d    = PFETCH;
                        end
                    end
                end
                PF_THEN_FETCH: begin
                    issue      = 1'b1;
                    issue_addr = pend_word_q;
                    state_d    = FETCH;
                end
                default: state_d = IDLE;
            endcase
        end

        if (rd_ok) begin
            if (cur_v_d && cur_tag_d == rd_word) begin
                din_d = byte_sel(cur_data_d, rd_hi);
            end else if (nxt_v_d && nxt_tag_d == rd_word) begin
                cur_tag_d  = nxt_tag_d;
                cur_data_d = nxt_data_d;
                cur_v_d    = 1'b1;
                nxt_v_d    = 1'b0;
                din_d      = byte_sel(nxt_data_d, rd_hi);
                if (PREFETCH && state_d == IDLE) begin
                    issue      = 1'b1;
                    issue_addr = rd_word + 1'b1;
                    state_d    = PFETCH;
                end
            end else begin
                pend_word_d = rd_word;
                pend_hi_d   = rd_hi;
                busy_d      = 1'b1;
                if (state_d == IDLE) begin
                    issue      = 1'b1;
                    issue_addr = rd_word;
                    state_d    = FETCH;
                end else if (rd_word == port_addr) begin
                    pf_demand_d = 1'b1;
                end else begin
                    state_d = PF_THEN_FETCH;
                end
            end
        end
    end

    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            cur_tag_q   <= '0;
            cur_data_q  <= '0;
            cur_v_q     <= 1'b0;
            nxt_tag_q   <= '0;
            nxt_data_q  <= '0;
            nxt_v_q     <= 1'b0;
            din_q       <= '0;
            busy_q      <= 1'b0;
            pend_word_q <= '0;
            pend_hi_q   <= 1'b0;
            pf_demand_q <= 1'b0;
            stale_q     <= 1'b0;
            upload_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_tag_q   <= cur_tag_d;
            cur_data_q  <= cur_data_d;
            cur_v_q     <= cur_v_d;
            nxt_tag_q   <= nxt_tag_d;
            nxt_data_q  <= nxt_data_d;
            nxt_v_q     <= nxt_v_d;
            din_q       <= din_d;
            busy_q      <= busy_d;
            pend_word_q <= pend_word_d;
            pend_hi_q   <= pend_hi_d;
            pf_demand_q <= pf_demand_d;
            stale_q     <= stale_d;
            upload_q    <= ioctl_upload_i;
        end
    end

    assign ioctl_din_o  = din_q;
    assign ioctl_busy_o = busy_q;
    assign port_a_o     = port_addr;
    assign port_ds_o    = 2'b11;
    assign port_we_o    = 1'b0;
    assign port_d_o     = 16'h0;

endmodule
